// File: rtl/carry8_pipe_pkg.sv
// Shared constants, helpers and payload types for the carry8 pipelined adder.
package carry8_pipe_pkg;

  localparam int unsigned SLICE_W = 8;

  // Number of 8-bit slices (and pipeline stages) for a given operand width.
  function automatic int unsigned slices(input int unsigned width);
    return width / SLICE_W;
  endfunction

  // Combinational result of one 8-bit carry-chain slice.
  typedef struct packed {
    logic [SLICE_W-1:0] sum;
    logic               co;
    logic               c_msb_in;
  } slice_res_t;

endpackage

// File: rtl/carry8_pipe_slice.sv
// One 8-bit carry-chain slice: S = a ^ b', DI = a, O = S ^ c, carry = S ? c : DI.
module carry8_pipe_slice
  import carry8_pipe_pkg::*;
(
  input  logic               ci,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bi,
  output logic [SLICE_W-1:0] o,
  output logic               co,
  output logic               c7_in
);

  logic [SLICE_W-1:0] s;
  logic [SLICE_W:0]   c;

  assign s = a ^ (b ^ {SLICE_W{bi}});

  // Ripple the propagate/generate mux chain through the slice.
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      c[i+1] = s[i] ? c[i] : a[i];
    end
  end

  assign o     = s ^ c[SLICE_W-1:0];
  assign co    = c[SLICE_W];
  assign c7_in = c[SLICE_W-1];

endmodule

// File: rtl/carry8_pipe_adder.sv
// Pipelined WIDTH-bit add/subtract, one register stage per 8-bit slice,
// with a global-advance valid/ready handshake.
module carry8_pipe_adder
  import carry8_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bi,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int unsigned SLICES = slices(WIDTH);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_chk
    $fatal(1, "carry8_pipe_adder: WIDTH must be a multiple of 8 and at least 8");
  end

  // Whole pipe shifts together whenever the output register is free or draining.
  logic adv_c;
  assign adv_c    = out_ready | ~out_valid;
  assign in_ready = adv_c;

  for (genvar k = 0; k < SLICES; k++) begin : g_stg
    localparam int unsigned SUM_W = SLICE_W * (k + 1);

    logic               v_d;
    logic               ci_d;
    logic               bi_d;
    logic [SLICE_W-1:0] a_d;
    logic [SLICE_W-1:0] b_d;
    logic [SUM_W-1:0]   sum_d;
    slice_res_t         res;
    logic               vld_q;
    logic               co_q;
    logic [SUM_W-1:0]   sum_q;

    // Stage inputs: fresh operands for stage 0, previous stage registers otherwise.
    if (k == 0) begin : g_src
      assign v_d   = in_valid;
      assign ci_d  = in_ci;
      assign bi_d  = in_bi;
      assign a_d   = in_a[SLICE_W-1:0];
      assign b_d   = in_b[SLICE_W-1:0];
      assign sum_d = res.sum;
    end else begin : g_src
      assign v_d   = g_stg[k-1].vld_q;
      assign ci_d  = g_stg[k-1].co_q;
      assign bi_d  = g_stg[k-1].g_rem.bi_q;
      assign a_d   = g_stg[k-1].g_rem.a_q[SLICE_W-1:0];
      assign b_d   = g_stg[k-1].g_rem.b_q[SLICE_W-1:0];
      assign sum_d = {res.sum, g_stg[k-1].sum_q};
    end

    carry8_pipe_slice u_slice (
      .ci    (ci_d),
      .a     (a_d),
      .b     (b_d),
      .bi    (bi_d),
      .o     (res.sum),
      .co    (res.co),
      .c7_in (res.c_msb_in)
    );

    // Valid, accumulated low sum bits and slice carry for this stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        co_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv_c) begin
        vld_q <= v_d;
        co_q  <= res.co;
        sum_q <= sum_d;
      end
    end

    // Raw operand slices still waiting for their turn; shrinks one slice per stage.
    if (k < SLICES - 1) begin : g_rem
      localparam int unsigned REM_W = SLICE_W * (SLICES - 1 - k);

      logic [REM_W-1:0] a_rem_d;
      logic [REM_W-1:0] b_rem_d;
      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] b_q;
      logic             bi_q;

      if (k == 0) begin : g_rd
        assign a_rem_d = in_a[WIDTH-1:SLICE_W];
        assign b_rem_d = in_b[WIDTH-1:SLICE_W];
      end else begin : g_rd
        assign a_rem_d = g_stg[k-1].g_rem.a_q[REM_W+SLICE_W-1:SLICE_W];
        assign b_rem_d = g_stg[k-1].g_rem.b_q[REM_W+SLICE_W-1:SLICE_W];
      end

      // Operand remainder and subtract flag carried to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          b_q  <= '0;
          bi_q <= 1'b0;
        end else if (adv_c) begin
          a_q  <= a_rem_d;
          b_q  <= b_rem_d;
          bi_q <= bi_d;
        end
      end
    end

    if (k == SLICES - 1) begin : g_tail
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv_c) begin
          ovf_q <= res.c_msb_in ^ res.co;
        end
      end
    end
  end

  assign out_valid = g_stg[SLICES-1].vld_q;
  assign out_sum   = g_stg[SLICES-1].sum_q;
  assign out_co    = g_stg[SLICES-1].co_q;
  assign out_ovf   = g_stg[SLICES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_carry8_pipe_adder.sv
// Bench for carry8_pipe_adder: 32-bit and 8-bit builds against an arithmetic model.
module tb_carry8_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv, ir, ibi, ici, ov, ordy, oco, oovf;
  logic [31:0] ia, ib, osum;
  logic        iv8, ir8, ibi8, ici8, ov8, ordy8, oco8, oovf8;
  logic [7:0]  ia8, ib8, osum8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  carry8_pipe_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir), .in_a(ia), .in_b(ib), .in_bi(ibi), .in_ci(ici),
    .out_valid(ov), .out_ready(ordy), .out_sum(osum), .out_co(oco), .out_ovf(oovf)
  );

  carry8_pipe_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_a(ia8), .in_b(ib8), .in_bi(ibi8), .in_ci(ici8),
    .out_valid(ov8), .out_ready(ordy8), .out_sum(osum8), .out_co(oco8), .out_ovf(oovf8)
  );

  // Reference: {co, ovf, sum} from plain wide arithmetic and sign rules.
  function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic bi, input logic ci);
    logic [31:0] bb;
    logic [32:0] full;
    logic        ovf;
    bb   = bi ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 33'(ci);
    ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
    return {full[32], ovf, full[31:0]};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                      input logic bi, input logic ci);
    logic [7:0] bb;
    logic [8:0] full;
    logic       ovf;
    bb   = bi ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 9'(ci);
    ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    return {full[8], ovf, full[7:0]};
  endfunction

  task automatic test_reset();
    #2;
    n_tests++;
    if ({ov, osum, oco, oovf} !== 35'd0) begin
      n_fail++; $display("FAIL reset32_outputs: got %h want 0", {ov, osum, oco, oovf});
    end
    n_tests++;
    if (ir !== 1'b1) begin
      n_fail++; $display("FAIL reset32_in_ready: got %b want 1", ir);
    end
    n_tests++;
    if ({ov8, osum8, oco8, oovf8, ir8} !== 12'b0000_0000_0001) begin
      n_fail++; $display("FAIL reset8_outputs: got %b want 000000000001", {ov8, osum8, oco8, oovf8, ir8});
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] tb_ [5] = '{32'h0000_0001, 32'd7, 32'd5, 32'h0000_0001, 32'h8000_0000};
    logic        tbi [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] es [5] = '{32'h0, 32'hFFFF_FFFE, 32'd2, 32'h8000_0000, 32'h0};
    logic        eco [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        eov [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; ia = ta[i]; ib = tb_[i]; ibi = tbi[i]; ici = tbi[i];
      n_tests++;
      if (ir !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_in_ready: got %b want 1", i, ir);
      end
      @(posedge clk); #1;
      iv = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      n_tests++;
      if (ov !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_early_valid: got %b want 0", i, ov);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({ov, osum, oco, oovf} !== {1'b1, es[i], eco[i], eov[i]}) begin
        n_fail++;
        $display("FAIL dir%0d_result: got v=%b sum=%h co=%b ovf=%b want v=1 sum=%h co=%b ovf=%b",
                 i, ov, osum, oco, oovf, es[i], eco[i], eov[i]);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (ov !== 1'b0) begin
      n_fail++; $display("FAIL dir_drain: got %b want 0", ov);
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] q[$];
    logic [33:0] got;
    int sent = 0;
    int rcv  = 0;
    logic exp_ir;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      iv   = (sent < 8);
      ia   = 32'(sent);
      ib   = 32'(sent) << 8;
      ibi  = 1'b0;
      ici  = 1'b0;
      ordy = !(c >= 5 && c <= 7);
      @(negedge clk);
      exp_ir = !(c >= 5 && c <= 7);
      n_tests++;
      if (ir !== exp_ir) begin
        n_fail++; $display("FAIL bp_in_ready_c%0d: got %b want %b", c, ir, exp_ir);
      end
      if (ov === 1'b1) begin
        got = {oco, oovf, osum};
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_unexpected_c%0d: got %h want no beat", c, got);
        end else if (got !== q[0]) begin
          n_fail++; $display("FAIL bp_result_c%0d: got %h want %h", c, got, q[0]);
        end
        if (ordy && q.size() != 0) begin
          void'(q.pop_front());
          rcv++;
        end
      end
      if (iv && ir) begin
        q.push_back(ref32(ia, ib, ibi, ici));
        sent++;
      end
      @(posedge clk); #1;
    end
    iv = 1'b0;
    n_tests++;
    if (rcv != 8 || q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d beats (%0d pending) want 8 (0)", rcv, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [33:0] e;
    ordy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; ia = 32'h100 + 32'(k); ib = 32'h10; ibi = 1'b0; ici = 1'b0;
      @(posedge clk); #1;
    end
    iv = 1'b0; ordy = 1'b0;
    @(posedge clk); #1;
    e = ref32(32'h100, 32'h10, 1'b0, 1'b0);
    n_tests++;
    if ({ov, oco, oovf, osum} !== {1'b1, e}) begin
      n_fail++; $display("FAIL mid_pre_reset: got v=%b %h want v=1 %h", ov, {oco, oovf, osum}, e);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ov, osum, oco, oovf} !== 35'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", {ov, osum, oco, oovf});
    end
    n_tests++;
    if (ir !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_in_ready: got %b want 1", ir);
    end
    #2 rst_n = 1'b1;
    ordy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (ov !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale_c%0d: got %b want 0", c, ov);
      end
    end
    iv = 1'b1; ia = 32'h1234_5678; ib = 32'h1111_1111; ibi = 1'b0; ici = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_tests++;
    if (ov !== 1'b0) begin
      n_fail++; $display("FAIL mid_next_early: got %b want 0", ov);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({ov, osum, oco, oovf} !== {1'b1, 32'h2345_678A, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL mid_next_result: got v=%b sum=%h co=%b ovf=%b want v=1 sum=2345678a co=0 ovf=0",
                         ov, osum, oco, oovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random32();
    logic [33:0] q[$];
    logic [33:0] got;
    int n_in = 0;
    for (int c = 0; c < 8000; c++) begin
      iv   = (n_in < 2000) && ($urandom_range(3) != 0);
      ia   = $urandom;
      ib   = $urandom;
      ibi  = 1'($urandom_range(1));
      ici  = 1'($urandom_range(1));
      ordy = ($urandom_range(3) != 0) || (n_in >= 2000);
      @(negedge clk);
      if (ov === 1'b1) begin
        got = {oco, oovf, osum};
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd32_unexpected_c%0d: got %h want no beat", c, got);
        end else if (got !== q[0]) begin
          n_fail++; $display("FAIL rnd32_result_c%0d: got %h want %h", c, got, q[0]);
        end
        if (ordy && q.size() != 0) void'(q.pop_front());
      end
      if (iv && ir) begin
        q.push_back(ref32(ia, ib, ibi, ici));
        n_in++;
      end
      @(posedge clk); #1;
      if (n_in >= 2000 && q.size() == 0) break;
    end
    iv = 1'b0;
    n_tests++;
    if (n_in != 2000 || q.size() != 0) begin
      n_fail++; $display("FAIL rnd32_drain: got %0d sent %0d pending want 2000 sent 0 pending", n_in, q.size());
    end
  endtask

  task automatic test_width8();
    logic [9:0] q[$];
    logic [9:0] got;
    int n_in = 0;
    iv8 = 1'b1; ia8 = 8'hFF; ib8 = 8'h01; ibi8 = 1'b0; ici8 = 1'b1; ordy8 = 1'b1;
    n_tests++;
    if (ir8 !== 1'b1) begin
      n_fail++; $display("FAIL w8_in_ready: got %b want 1", ir8);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    n_tests++;
    if ({ov8, osum8, oco8, oovf8} !== {1'b1, 8'h01, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL w8_directed: got v=%b sum=%h co=%b ovf=%b want v=1 sum=01 co=1 ovf=0",
                         ov8, osum8, oco8, oovf8);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ov8 !== 1'b0) begin
      n_fail++; $display("FAIL w8_drain: got %b want 0", ov8);
    end
    for (int c = 0; c < 40000; c++) begin
      iv8   = (n_in < 10000) && ($urandom_range(3) != 0);
      ia8   = 8'($urandom);
      ib8   = 8'($urandom);
      ibi8  = 1'($urandom_range(1));
      ici8  = 1'($urandom_range(1));
      ordy8 = ($urandom_range(3) != 0) || (n_in >= 10000);
      @(negedge clk);
      if (ov8 === 1'b1) begin
        got = {oco8, oovf8, osum8};
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd8_unexpected_c%0d: got %h want no beat", c, got);
        end else if (got !== q[0]) begin
          n_fail++; $display("FAIL rnd8_result_c%0d: got %h want %h", c, got, q[0]);
        end
        if (ordy8 && q.size() != 0) void'(q.pop_front());
      end
      if (iv8 && ir8) begin
        q.push_back(ref8(ia8, ib8, ibi8, ici8));
        n_in++;
      end
      @(posedge clk); #1;
      if (n_in >= 10000 && q.size() == 0) break;
    end
    iv8 = 1'b0;
    n_tests++;
    if (n_in != 10000 || q.size() != 0) begin
      n_fail++; $display("FAIL rnd8_drain: got %0d sent %0d pending want 10000 sent 0 pending", n_in, q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv = 1'b0; ia = '0; ib = '0; ibi = 1'b0; ici = 1'b0; ordy = 1'b0;
    iv8 = 1'b0; ia8 = '0; ib8 = '0; ibi8 = 1'b0; ici8 = 1'b0; ordy8 = 1'b0;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random32();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
